// File: rtl/ifetch_unit.sv
// Instruction fetch: drives a registered imem, buffers responses in a 2-entry in-order queue.
// Latency 2 edges from reset/redirect to first out_valid; out_ready low stalls fetch once the buffer would overflow.

module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

module ifetch_unit #(
  parameter int PC_WIDTH_LENGTH   = 32,
  parameter int INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
  input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_WIDTH_LENGTH-1:0] out_inst,
  output logic [PC_WIDTH_LENGTH-1:0]   out_pc,
  output logic                         misalign_err
);

  localparam int WW = PC_WIDTH_LENGTH - 2;
  localparam int DW = INST_WIDTH_LENGTH + WW;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t        state;
  logic [WW-1:0] pc;
  logic [WW-1:0] inflight_pc;
  logic          inflight;
  logic [1:0]    count;
  logic [DW-1:0] head_dat;
  logic [2:0]    occ;
  logic          run, redir, redir_ok, redir_bad, pop, push, fire;

  // PCs are kept as word addresses so the low two bits can never be nonzero.
  assign run       = (state == RUN);
  assign redir     = run & redirect_valid;
  assign redir_ok  = redir & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redir & (redirect_pc[1:0] != 2'b00);
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redir;
  assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
  assign fire      = run & ~redirect_valid & (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC[PC_WIDTH_LENGTH-1:2];
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redir_ok) begin
            pc       <= redirect_pc[PC_WIDTH_LENGTH-1:2];
            inflight <= 1'b0;
          end else if (redir_bad) begin
            state        <= FAULT;
            misalign_err <= 1'b1;
            inflight     <= 1'b0;
          end else if (fire) begin
            inflight    <= 1'b1;
            inflight_pc <= pc;
            pc          <= pc + WW'(1);
          end else begin
            inflight <= 1'b0;
          end
        end
        FAULT: begin
          inflight <= 1'b0;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  ifetch_fifo #(
    .WIDTH (DW),
    .DEPTH (2)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redir),
    .push     (push),
    .push_dat ({imem_inst, inflight_pc}),
    .pop      (pop),
    .count    (count),
    .head_dat (head_dat)
  );

  assign imem_pc   = {pc, 2'b00};
  assign out_valid = (count != 2'd0);
  assign out_inst  = head_dat[DW-1:WW];
  assign out_pc    = {head_dat[WW-1:0], 2'b00};

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == 2'd2 && !pop && !redir));
  a_fault_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FAULT) |-> !out_valid);

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eimem;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  ifetch_unit #(
    .PC_WIDTH_LENGTH   (32),
    .INST_WIDTH_LENGTH (32),
    .RESET_PC          (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Registered memory: word n holds value n.
  always @(posedge clk) imem_inst <= {2'b00, imem_pc[31:2]};

  function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rpc,
                             input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                             input logic [31:0] eimem, input logic eerr);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.ev = ev;
    r.epc = epc; r.einst = einst; r.eimem = eimem; r.eerr = eerr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst);
    check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
    if (ev) begin
      check({tag, " out_pc"}, out_pc, epc);
      check({tag, " out_inst"}, out_inst, einst);
    end
  endtask

  initial begin
    // k = cycles after reset release; inputs shown apply to the edge ending cycle k
    vecs.push_back(v(0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(v(0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 0));
    for (int i = 2; i < 12; i++)
      vecs.push_back(v(0, 0, 32'h0, 1, 32'h0, 32'h0, 32'h8, 0));
    vecs.push_back(v(1, 0, 32'h0, 1, 32'h0, 32'h0, 32'h8, 0));
    vecs.push_back(v(1, 0, 32'h0, 1, 32'h4, 32'h1, 32'hC, 0));
    vecs.push_back(v(1, 0, 32'h0, 1, 32'h8, 32'h2, 32'h10, 0));
    vecs.push_back(v(0, 0, 32'h0, 1, 32'hC, 32'h3, 32'h14, 0));
    vecs.push_back(v(0, 1, 32'h100, 1, 32'hC, 32'h3, 32'h14, 0));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h100, 0));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h104, 0));
    vecs.push_back(v(1, 0, 32'h0, 1, 32'h100, 32'h40, 32'h108, 0));
    vecs.push_back(v(1, 1, 32'hFFFF_FFFC, 1, 32'h104, 32'h41, 32'h10C, 0));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(v(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h4, 0));
    vecs.push_back(v(1, 1, 32'h102, 1, 32'h0, 32'h0, 32'h8, 0));
    vecs.push_back(v(1, 1, 32'h200, 0, 32'h0, 32'h0, 32'h8, 1));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h8, 1));
    vecs.push_back(v(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h8, 1));

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset imem_pc", imem_pc, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      exp_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einst);
      check($sformatf("vec%0d imem_pc", i), imem_pc, vecs[i].eimem);
      check($sformatf("vec%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].eerr});
      step();
    end
    redirect_valid = 1'b0;

    // Reset clears the fault and fetch restarts from the reset PC.
    rst_n = 1'b0;
    #1;
    check("fault reset out_valid", {31'b0, out_valid}, 32'h0);
    check("fault reset misalign_err", {31'b0, misalign_err}, 32'h0);
    check("fault reset imem_pc", imem_pc, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_out("rs k0", 1'b0, 32'h0, 32'h0);
    step();
    exp_out("rs k1", 1'b0, 32'h0, 32'h0);
    step();
    exp_out("rs k2", 1'b1, 32'h0, 32'h0);
    step();
    exp_out("rs k3", 1'b1, 32'h4, 32'h1);
    step();
    exp_out("rs k4", 1'b1, 32'h8, 32'h2);
    check("rs k4 misalign_err", {31'b0, misalign_err}, 32'h0);

    // One-cycle reset while output is valid: out_valid drops without a clock edge.
    rst_n = 1'b0;
    #1;
    check("midrst out_valid async", {31'b0, out_valid}, 32'h0);
    check("midrst imem_pc async", imem_pc, 32'h0);
    step();
    rst_n = 1'b1;
    exp_out("mr k0", 1'b0, 32'h0, 32'h0);
    step();
    exp_out("mr k1", 1'b0, 32'h0, 32'h0);
    step();
    exp_out("mr k2", 1'b1, 32'h0, 32'h0);
    step();
    exp_out("mr k3", 1'b1, 32'h4, 32'h1);
    check("mr k3 imem_pc", imem_pc, 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
